click_fork_n: RTL and testbench

CLICK_FORK_N -- requirements
Module: click_fork_n

---
 rtl/click_pkg.sv | 14 +
 rtl/click_sync.sv | 42 ++++
 rtl/click_fork_n.sv | 111 +++++++++++
 tb/tb_click_fork_n.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/click_pkg.sv
// Shared types and constants for the click-style 2-phase handshake blocks.
package click_pkg;

  typedef logic phase_t;

  typedef enum logic {
    IDLE,
    WAIT
  } fork_state_t;

  localparam int TOKCNT_W     = 16;
  localparam int MAX_CHANNELS = 8;

endpackage

// File: rtl/click_sync.sv
// Multi-bit flop-chain synchroniser for 2-phase handshake lines.
// STAGES = 0 degenerates to a straight wire.
module click_sync
  import click_pkg::*;
#(
  parameter int     W          = 1,
  parameter int     STAGES     = 2,
  parameter phase_t PHASE_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic sync_unused;
      assign sync_unused = ^{clk, rst};
      assign q = d;
    end else begin : g_chain
      logic [W-1:0] stage [STAGES];

      // Each line is an independent 2-phase event wire, so per-bit sync is safe.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            stage[i] <= {W{PHASE_INIT}};
          end
        end else begin
          stage[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/click_fork_n.sv
// 2-phase fork: one producer token is broadcast to the channels selected by
// in_sel, and acknowledged upstream once every selected channel has answered.
module click_fork_n
  import click_pkg::*;
#(
  parameter int     N           = 2,
  parameter int     DW          = 8,
  parameter phase_t PHASE_INIT  = 1'b0,
  parameter int     SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_req,
  input  logic [DW-1:0]       in_data,
  input  logic [N-1:0]        in_sel,
  output logic                in_ack,
  output logic [N-1:0]        out_req,
  output logic [DW-1:0]       out_data,
  input  logic [N-1:0]        out_ack,
  output logic                busy,
  output logic [TOKCNT_W-1:0] tok_cnt
);

  fork_state_t         state, state_nx;
  phase_t              in_ack_q, in_ack_nx;
  logic [N-1:0]        out_req_q, out_req_nx;
  logic [N-1:0]        sel_q, sel_nx;
  logic [DW-1:0]       out_data_q, out_data_nx;
  logic [TOKCNT_W-1:0] tok_cnt_q, tok_cnt_nx;

  logic                in_req_s;
  logic [N-1:0]        out_ack_s;
  logic                pending;
  logic                done;

  click_sync #(.W(1), .STAGES(SYNC_STAGES), .PHASE_INIT(PHASE_INIT)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (in_req),
    .q   (in_req_s)
  );

  click_sync #(.W(N), .STAGES(SYNC_STAGES), .PHASE_INIT(PHASE_INIT)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (out_ack),
    .q   (out_ack_s)
  );

  assign pending = (in_req_s != in_ack_q);
  // Unselected channels are forced true so stray acks there cannot matter.
  assign done    = &((out_ack_s ~^ out_req_q) | ~sel_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ack_q   <= PHASE_INIT;
      out_req_q  <= {N{PHASE_INIT}};
      sel_q      <= '0;
      out_data_q <= '0;
      tok_cnt_q  <= '0;
    end else begin
      state      <= state_nx;
      in_ack_q   <= in_ack_nx;
      out_req_q  <= out_req_nx;
      sel_q      <= sel_nx;
      out_data_q <= out_data_nx;
      tok_cnt_q  <= tok_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    in_ack_nx   = in_ack_q;
    out_req_nx  = out_req_q;
    sel_nx      = sel_q;
    out_data_nx = out_data_q;
    tok_cnt_nx  = tok_cnt_q;
    unique case (state)
      IDLE: begin
        if (pending) begin
          if (in_sel != '0) begin
            out_data_nx = in_data;
            sel_nx      = in_sel;
            out_req_nx  = out_req_q ^ in_sel;
            state_nx    = WAIT;
          end else begin
            // Empty mask: the token is consumed without touching any channel.
            in_ack_nx  = ~in_ack_q;
            tok_cnt_nx = tok_cnt_q + TOKCNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (done) begin
          in_ack_nx  = ~in_ack_q;
          tok_cnt_nx = tok_cnt_q + TOKCNT_W'(1);
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ack   = in_ack_q;
  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign tok_cnt  = tok_cnt_q;
  assign busy     = (state == WAIT);

endmodule

// File: tb/tb_click_fork_n.sv
// Bench for click_fork_n: directed scenarios plus counter wrap on a 2-channel
// unsynchronised instance, randomized traffic with a scoreboard on a 4-channel one.
module tb_click_fork_n;

  localparam int CLK_HALF = 5;
  localparam int NTOK_B   = 2000;

  logic clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  logic        rst_a     = 1'b1;
  logic        a_in_req  = 1'b0;
  logic [7:0]  a_in_data = 8'h00;
  logic [1:0]  a_in_sel  = 2'b00;
  logic        a_in_ack;
  logic [1:0]  a_out_req;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ack = 2'b00;
  logic        a_busy;
  logic [15:0] a_tok_cnt;

  logic        rst_b     = 1'b1;
  logic        b_in_req  = 1'b1;
  logic [7:0]  b_in_data = 8'h00;
  logic [3:0]  b_in_sel  = 4'h0;
  logic        b_in_ack;
  logic [3:0]  b_out_req;
  logic [7:0]  b_out_data;
  logic [3:0]  b_out_ack = 4'hF;
  logic        b_busy;
  logic [15:0] b_tok_cnt;

  click_fork_n #(.N(2), .DW(8), .PHASE_INIT(1'b0), .SYNC_STAGES(0)) dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .in_req   (a_in_req),
    .in_data  (a_in_data),
    .in_sel   (a_in_sel),
    .in_ack   (a_in_ack),
    .out_req  (a_out_req),
    .out_data (a_out_data),
    .out_ack  (a_out_ack),
    .busy     (a_busy),
    .tok_cnt  (a_tok_cnt)
  );

  click_fork_n #(.N(4), .DW(8), .PHASE_INIT(1'b1), .SYNC_STAGES(2)) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .in_req   (b_in_req),
    .in_data  (b_in_data),
    .in_sel   (b_in_sel),
    .in_ack   (b_in_ack),
    .out_req  (b_out_req),
    .out_data (b_out_data),
    .out_ack  (b_out_ack),
    .busy     (b_busy),
    .tok_cnt  (b_tok_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract token-level model: what each output must hold after every edge.
  typedef struct packed {
    bit            ack;
    bit [7:0]      req;
    bit [7:0]      data;
    bit [7:0]      sel;
    bit [15:0]     cnt;
    bit            waiting;
    bit [3:0]      rq_h;
    bit [3:0][7:0] ak_h;
  } model_t;

  function automatic model_t model_reset(bit pi);
    model_t r;
    r         = '0;
    r.ack     = pi;
    r.req     = {8{pi}};
    r.rq_h    = {4{pi}};
    r.ak_h    = {4{{8{pi}}}};
    return r;
  endfunction

  function automatic model_t model_step(model_t m, int sync, int n, bit inreq,
                                        bit [7:0] indata, bit [7:0] insel, bit [7:0] outack);
    model_t   r = m;
    bit       rs;
    bit [7:0] as;
    bit [7:0] mask;
    mask = 8'((1 << n) - 1);
    if (sync == 0) begin
      rs = inreq;
      as = outack;
    end else begin
      rs = m.rq_h[sync-1];
      as = m.ak_h[sync-1];
    end
    if (!m.waiting) begin
      if (rs != m.ack) begin
        if ((insel & mask) != 8'h00) begin
          r.data    = indata;
          r.sel     = insel & mask;
          r.req     = m.req ^ (insel & mask);
          r.waiting = 1'b1;
        end else begin
          r.ack = ~m.ack;
          r.cnt = m.cnt + 16'd1;
        end
      end
    end else if (((as ^ m.req) & m.sel) == 8'h00) begin
      r.ack     = ~m.ack;
      r.cnt     = m.cnt + 16'd1;
      r.waiting = 1'b0;
    end
    r.rq_h = {m.rq_h[2:0], inreq};
    r.ak_h = {m.ak_h[2:0], outack};
    return r;
  endfunction

  model_t ma;
  model_t mb;

  // Inputs change just after the rising edge, so on the falling edge they are
  // exactly what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_a) begin
      ma = model_reset(1'b0);
    end else begin
      checkOutput("a_in_ack",   a_in_ack,   ma.ack);
      checkOutput("a_out_req",  a_out_req,  ma.req[1:0]);
      checkOutput("a_out_data", a_out_data, ma.data);
      checkOutput("a_busy",     a_busy,     ma.waiting);
      checkOutput("a_tok_cnt",  a_tok_cnt,  ma.cnt);
      ma = model_step(ma, 0, 2, a_in_req, a_in_data, {6'b0, a_in_sel}, {6'b0, a_out_ack});
    end
    if (rst_b) begin
      mb = model_reset(1'b1);
    end else begin
      checkOutput("b_in_ack",   b_in_ack,   mb.ack);
      checkOutput("b_out_req",  b_out_req,  mb.req[3:0]);
      checkOutput("b_out_data", b_out_data, mb.data);
      checkOutput("b_busy",     b_busy,     mb.waiting);
      checkOutput("b_tok_cnt",  b_tok_cnt,  mb.cnt);
      mb = model_step(mb, 2, 4, b_in_req, b_in_data, {4'b0, b_in_sel}, {4'b0, b_out_ack});
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] sel);
    a_in_data = data;
    a_in_sel  = sel;
    a_in_req  = ~a_in_req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runA();
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    checkOutput("a_rst_in_ack",   a_in_ack,   0);
    checkOutput("a_rst_out_req",  a_out_req,  0);
    checkOutput("a_rst_out_data", a_out_data, 0);
    checkOutput("a_rst_busy",     a_busy,     0);
    checkOutput("a_rst_tok_cnt",  a_tok_cnt,  0);

    applyStimulus(8'hA5, 2'b11);
    tick();
    checkOutput("s1_out_req",  a_out_req,  2'b11);
    checkOutput("s1_out_data", a_out_data, 8'hA5);
    checkOutput("s1_busy",     a_busy,     1);
    checkOutput("s1_in_ack_early", a_in_ack, 0);
    a_out_ack = 2'b11;
    tick();
    checkOutput("s1_in_ack",  a_in_ack,  1);
    checkOutput("s1_tok_cnt", a_tok_cnt, 1);
    checkOutput("s1_model_cnt", ma.cnt,  1);

    applyStimulus(8'h3C, 2'b10);
    tick();
    checkOutput("s2_out_req",  a_out_req,  2'b01);
    checkOutput("s2_out_data", a_out_data, 8'h3C);
    a_out_ack[0] = ~a_out_ack[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("s2_busy_hold",   a_busy,   1);
      checkOutput("s2_in_ack_hold", a_in_ack, 1);
    end
    a_out_ack[1] = ~a_out_ack[1];
    tick();
    checkOutput("s2_in_ack",  a_in_ack,  0);
    checkOutput("s2_tok_cnt", a_tok_cnt, 2);
    a_out_ack[0] = ~a_out_ack[0];
    tick();
    checkOutput("s2_idle_in_ack", a_in_ack, 0);
    checkOutput("s2_idle_busy",   a_busy,   0);

    applyStimulus(8'h5A, 2'b11);
    tick();
    checkOutput("s3_out_req", a_out_req, 2'b10);
    a_out_ack[0] = ~a_out_ack[0];
    a_in_data    = 8'hFF;
    a_in_sel     = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("s3_busy_hold",   a_busy,     1);
      checkOutput("s3_in_ack_hold", a_in_ack,   0);
      checkOutput("s3_data_hold",   a_out_data, 8'h5A);
    end
    a_out_ack[1] = ~a_out_ack[1];
    tick();
    checkOutput("s3_in_ack",  a_in_ack,   1);
    checkOutput("s3_tok_cnt", a_tok_cnt,  3);
    checkOutput("s3_data",    a_out_data, 8'h5A);

    applyStimulus(8'h77, 2'b00);
    tick();
    checkOutput("s4_in_ack",   a_in_ack,   0);
    checkOutput("s4_tok_cnt",  a_tok_cnt,  4);
    checkOutput("s4_out_req",  a_out_req,  2'b10);
    checkOutput("s4_out_data", a_out_data, 8'h5A);
    checkOutput("s4_busy",     a_busy,     0);

    applyStimulus(8'h99, 2'b01);
    tick();
    checkOutput("s5_busy",    a_busy,    1);
    checkOutput("s5_out_req", a_out_req, 2'b11);
    #2;
    rst_a = 1'b1;
    #1;
    checkOutput("s5_rst_out_req",  a_out_req,  0);
    checkOutput("s5_rst_in_ack",   a_in_ack,   0);
    checkOutput("s5_rst_tok_cnt",  a_tok_cnt,  0);
    checkOutput("s5_rst_busy",     a_busy,     0);
    checkOutput("s5_rst_out_data", a_out_data, 0);
    a_in_req  = 1'b0;
    a_out_ack = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    applyStimulus(8'hC3, 2'b11);
    tick();
    checkOutput("s5_next_out_req", a_out_req, 2'b11);
    a_out_ack = 2'b11;
    tick();
    checkOutput("s5_next_in_ack",   a_in_ack,   1);
    checkOutput("s5_next_tok_cnt",  a_tok_cnt,  1);
    checkOutput("s5_next_out_data", a_out_data, 8'hC3);

    // Empty-mask tokens complete one per cycle, which makes the wrap cheap.
    a_in_sel = 2'b00;
    for (int k = 0; k < 65534; k++) begin
      a_in_data = 8'($urandom);
      a_in_req  = ~a_in_req;
      tick();
    end
    checkOutput("wrap_ffff", a_tok_cnt, 16'hFFFF);
    a_in_req = ~a_in_req;
    tick();
    checkOutput("wrap_zero", a_tok_cnt, 16'h0000);
    a_in_req = ~a_in_req;
    tick();
    checkOutput("wrap_one",     a_tok_cnt, 16'h0001);
    checkOutput("wrap_handshake", a_in_ack, a_in_req);
  endtask

  logic [7:0] bq [4][$];
  bit   [3:0] b_seen = '0;
  int         b_dly [4];
  bit         b_run  = 1'b0;

  task automatic waitAckB();
    int w = 0;
    while (b_in_ack != b_in_req && w < 500) begin
      tick();
      w++;
    end
    checkOutput("b_producer_wait", b_in_ack, b_in_req);
  endtask

  task automatic runB();
    int ntok = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    b_run = 1'b1;
    checkOutput("b_rst_in_ack",  b_in_ack,  1);
    checkOutput("b_rst_out_req", b_out_req, 4'hF);
    checkOutput("b_rst_tok_cnt", b_tok_cnt, 0);
    checkOutput("b_rst_busy",    b_busy,    0);
    for (int t = 0; t < NTOK_B; t++) begin
      logic [7:0] d;
      logic [3:0] s;
      waitAckB();
      if (b_in_ack != b_in_req) break;
      d = 8'($urandom);
      s = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        if (s[i]) bq[i].push_back(d);
      end
      b_in_data = d;
      b_in_sel  = s;
      b_in_req  = ~b_in_req;
      ntok++;
      if ($urandom_range(0, 3) == 0) tick();
    end
    waitAckB();
    checkOutput("b_tok_cnt_final", b_tok_cnt, 16'(ntok));
    for (int i = 0; i < 4; i++) begin
      checkOutput("b_queue_drained", bq[i].size(), 0);
    end
  endtask

  // Randomly-delayed consumers; each checks the data it receives per channel.
  initial begin
    forever begin
      tick();
      if (b_run) begin
        for (int i = 0; i < 4; i++) begin
          if (!b_seen[i] && b_out_req[i] != b_out_ack[i]) begin
            if (bq[i].size() == 0) begin
              tests++;
              fails++;
              $display("[TB] FAIL b_ch%0d_extra: got token %0h, expected none", i, b_out_data);
            end else begin
              checkOutput("b_ch_data", b_out_data, bq[i].pop_front());
            end
            b_seen[i] = 1'b1;
            b_dly[i]  = $urandom_range(0, 3);
          end
          if (b_seen[i]) begin
            if (b_dly[i] == 0) begin
              b_out_ack[i] = ~b_out_ack[i];
              b_seen[i]    = 1'b0;
            end else begin
              b_dly[i]--;
            end
          end
        end
      end
    end
  end

  initial begin
    #(90000 * 2 * CLK_HALF);
    tests++;
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    fork
      runA();
      runB();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
